// File: rtl/mem_ctrl_if.sv
// Memory-controller request/response bus.
// The requester (MAR/MDR side) uses the master modport. The controller uses
// the slave modport. Clock and reset are not part of this bus; they stay
// plain ports on the controller.
interface mem_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 9
);
   logic                  read_req;
   logic                  write_req;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  busy;
   logic                  done;
   logic                  error;

   modport master (
      output read_req, write_req, address, write_data,
      input  read_data, busy, done, error
   );

   modport slave (
      input  read_req, write_req, address, write_data,
      output read_data, busy, done, error
   );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port word RAM behind a request/done handshake.
//
// A request is accepted only in IDLE. The accepting edge latches the address,
// the write data and the direction. The FSM then steps
// WAIT (optional) -> XFER -> DONE -> IDLE.
// The RAM access happens on the edge that closes XFER. done pulses for one
// cycle in DONE. When read_req and write_req are both high in IDLE, error
// pulses and no access is made.
//
// Configuration macro: MEM_CTRL_WAIT_EN
//   defined   - a WAIT state lasting WAIT_CYCLES cycles (0..15) precedes XFER.
//   undefined - there is no WAIT state or counter, and WAIT_CYCLES has no effect.
module mem_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 9,
   parameter int WAIT_CYCLES = 2
) (
   input logic          clock,
   input logic          clear,
   mem_ctrl_if.slave    bus
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef MEM_CTRL_WAIT_EN
   typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;
   // The counter is 4 bits wide, so larger settings saturate at 15.
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 15) ? 4'd15 : 4'(WAIT_CYCLES);
   logic [3:0] wait_cnt;
`else
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
   // This build has no wait states. WAIT_CYCLES stays in the parameter list so
   // that both builds have the same instantiation signature.
   if (WAIT_CYCLES > 15) begin : g_wait_cycles_unused
   end
`endif

   state_t                state;
   logic                  is_write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] read_data_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  error_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign bus.read_data = read_data_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.error     = error_q;

   // Control FSM with registered busy/done/error/read_data outputs.
   // NOTE: all sequential state is assigned with non-blocking (<=) so every
   // register samples the values from before the edge. This avoids ordering races.
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state       <= IDLE;
         is_write_q  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         read_data_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
`ifdef MEM_CTRL_WAIT_EN
         wait_cnt    <= 4'd0;
`endif
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.read_req && bus.write_req) begin
                  error_q <= 1'b1;
               end else if (bus.read_req || bus.write_req) begin
                  is_write_q <= bus.write_req;
                  addr_q     <= bus.address;
                  wdata_q    <= bus.write_data;
                  busy_q     <= 1'b1;
`ifdef MEM_CTRL_WAIT_EN
                  if (WAIT_LOAD != 4'd0) begin
                     wait_cnt <= WAIT_LOAD;
                     state    <= WAIT;
                  end else begin
                     state <= XFER;
                  end
`else
                  state <= XFER;
`endif
               end
            end
`ifdef MEM_CTRL_WAIT_EN
            WAIT: begin
               if (wait_cnt <= 4'd1) begin
                  wait_cnt <= 4'd0;
                  state    <= XFER;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
`endif
            XFER: begin
               if (!is_write_q) begin
                  read_data_q <= mem[addr_q];
               end
               busy_q <= 1'b0;
               done_q <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // RAM write port: commits on the edge that closes XFER.
   // NOTE: the RAM array is deliberately not reset, so that it maps onto block
   // RAM and keeps its contents through clear. The FSM drops out of XFER
   // asynchronously on clear, so an interrupted write never commits.
   always_ff @(posedge clock) begin
      if (state == XFER && is_write_q) begin
         mem[addr_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl.
// The expected timing comes from the access latency: (wait states + 1) busy
// cycles after the accepting edge, then one done cycle. A memory model kept
// as an associative array supplies the expected read data.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
module tb_mem_ctrl;

   localparam int DW = 32;
   localparam int AW = 9;
   localparam int WAIT_CYCLES = 2;
`ifdef MEM_CTRL_WAIT_EN
   localparam int LAT = WAIT_CYCLES;
`else
   localparam int LAT = 0;
`endif

   logic clock;
   logic clear;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [DW-1:0] model_mem [int];
   logic [DW-1:0] model_rd;

   mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mem_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .WAIT_CYCLES(WAIT_CYCLES)
   ) dut (
      .clock(clock),
      .clear(clear),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      @(negedge clock);
   endtask

   // One complete access. The request is dropped after the accepting edge.
   // With scramble=1, the address and write data are also corrupted at that
   // point; the latched copies must still be used.
   task automatic access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit scramble);
      bus.read_req   = !wr;
      bus.write_req  = wr;
      bus.address    = a;
      bus.write_data = d;
      tick();
      bus.read_req  = 1'b0;
      bus.write_req = 1'b0;
      if (scramble) begin
         bus.address    = ~a;
         bus.write_data = ~d;
      end
      for (int i = 0; i <= LAT; i++) begin
         check("busy_in_flight", {31'd0, bus.busy}, 32'd1);
         check("done_low_in_flight", {31'd0, bus.done}, 32'd0);
         tick();
      end
      if (wr) model_mem[int'(a)] = d;
      else    model_rd = model_mem[int'(a)];
      check("done_pulse", {31'd0, bus.done}, 32'd1);
      check("busy_low_done", {31'd0, bus.busy}, 32'd0);
      check("read_data", bus.read_data, model_rd);
      tick();
      check("done_one_cycle", {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] prev_rd;
      int            first_done;
      int            n_ticks;
      int            wr_addrs[$];

      clear          = 1'b0;
      bus.read_req   = 1'b0;
      bus.write_req  = 1'b0;
      bus.address    = '0;
      bus.write_data = '0;
      model_rd       = '0;
      repeat (2) @(negedge clock);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_error", {31'd0, bus.error}, 32'd0);
      check("rst_read_data", bus.read_data, 32'd0);
      clear = 1'b1;
      tick();
      check("idle_busy", {31'd0, bus.busy}, 32'd0);

      // Write followed by read of the same word.
      access(1'b1, 9'h010, 32'hDEADBEEF, 1'b0);
      access(1'b0, 9'h010, 32'h0, 1'b0);

      // Random traffic; reads only touch words already written.
      for (int i = 0; i < 24; i++) begin
         if (wr_addrs.size() == 0 || $urandom_range(0, 1) == 0) begin
            a = 9'h100 + 9'($urandom_range(0, 15));
            d = $urandom;
            access(1'b1, a, d, 1'b0);
            wr_addrs.push_back(int'(a));
         end else begin
            a = 9'(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]);
            access(1'b0, a, 32'h0, 1'b0);
         end
      end

      // Both requests together: error pulse only, no access.
      access(1'b0, 9'h010, 32'h0, 1'b0);
      bus.read_req   = 1'b1;
      bus.write_req  = 1'b1;
      bus.address    = 9'h010;
      bus.write_data = 32'h11111111;
      tick();
      check("err_pulse", {31'd0, bus.error}, 32'd1);
      check("err_busy", {31'd0, bus.busy}, 32'd0);
      check("err_read_data", bus.read_data, model_rd);
      bus.read_req  = 1'b0;
      bus.write_req = 1'b0;
      tick();
      check("err_one_cycle", {31'd0, bus.error}, 32'd0);
      check("err_busy_after", {31'd0, bus.busy}, 32'd0);
      access(1'b0, 9'h010, 32'h0, 1'b0);

      // Reset while a write is in flight: the write is lost and outputs clear.
      access(1'b1, 9'h020, 32'hAAAA5555, 1'b0);
      access(1'b0, 9'h020, 32'h0, 1'b0);
      bus.write_req  = 1'b1;
      bus.address    = 9'h020;
      bus.write_data = 32'h12345678;
      tick();
      bus.write_req = 1'b0;
      check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
      clear = 1'b0;
      #1;
      model_rd = '0;
      check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("mid_rst_done", {31'd0, bus.done}, 32'd0);
      check("mid_rst_read_data", bus.read_data, 32'd0);
      tick();
      clear = 1'b1;
      tick();
      check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
      check("post_rst_done", {31'd0, bus.done}, 32'd0);
      access(1'b0, 9'h020, 32'h0, 1'b0);

      // read_req held high: done every LAT+3 cycles, read_data stable.
      access(1'b1, 9'h001, 32'hC0FFEE01, 1'b0);
      prev_rd        = model_rd;
      first_done     = LAT + 2;
      n_ticks        = first_done + 3 * (LAT + 3);
      bus.read_req   = 1'b1;
      bus.address    = 9'h001;
      for (int k = 1; k <= n_ticks; k++) begin
         tick();
         check("hold_done",
               {31'd0, bus.done},
               {31'd0, (k >= first_done) && (((k - first_done) % (LAT + 3)) == 0)});
         check("hold_read_data", bus.read_data,
               (k >= first_done) ? model_mem[1] : prev_rd);
      end
      bus.read_req = 1'b0;
      model_rd = model_mem[1];
      tick();
      check("hold_release_busy", {31'd0, bus.busy}, 32'd0);

      // Inputs changed mid-access: the latched address/data are used.
      access(1'b1, 9'h0F0, 32'h5A5A0001, 1'b0);
      access(1'b1, 9'h00F, 32'h76543210, 1'b1);
      access(1'b0, 9'h00F, 32'h0, 1'b0);
      access(1'b0, 9'h0F0, 32'h0, 1'b0);

      // Highest address.
      access(1'b1, 9'h1FF, 32'h0F0F0F0F, 1'b0);
      access(1'b0, 9'h1FF, 32'h0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 9, giving the word address width; the internal RAM depth is 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 2, giving the access wait states (range 0..15).
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes occur on the rising edge.
REQ-005 The block SHALL have port clear, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port read_req, input, 1 bit: request a memory read, level-sensitive.
REQ-007 The block SHALL have port write_req, input, 1 bit: request a memory write, level-sensitive.
REQ-008 The block SHALL have port address, input, ADDR_WIDTH bits: word address from MAR.
REQ-009 The block SHALL have port write_data, input, DATA_WIDTH bits: write word from the MDR memory side.
REQ-010 The block SHALL have port read_data, output, DATA_WIDTH bits: read word to the MDR memory side.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a request is in flight.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 The block SHALL have port error, output, 1 bit: one-cycle pulse when read_req and write_req are sampled high together.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, XFER and DONE.
REQ-015 In IDLE, at a rising edge with exactly one request high, the FSM SHALL latch address, write_data and the direction, then go to WAIT (WAIT_CYCLES>0) or XFER (WAIT_CYCLES=0); call this edge E0.
REQ-016 In IDLE, at an edge with both requests high, the FSM SHALL perform no access, stay in IDLE and assert error for the following cycle only.
REQ-017 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a down-counter loaded at E0, then go to XFER.
REQ-018 XFER SHALL last one cycle: at its closing edge (E0+WAIT_CYCLES+1) a write commits the latched data to RAM, or a read loads read_data from RAM[latched address].
REQ-019 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-020 busy SHALL be 1 in WAIT and XFER, and 0 in IDLE and DONE.
REQ-021 Requests SHALL be sampled only in IDLE; changes to inputs in WAIT, XFER or DONE SHALL have no effect.
REQ-022 A request held high through DONE SHALL be accepted again at the edge leaving IDLE, giving a minimum request spacing of WAIT_CYCLES+3 cycles.
REQ-023 read_data SHALL hold its value until the next completed read; writes and errors SHALL NOT change it.
REQ-024 A read of a location written earlier SHALL return the last committed value; a read of a never-written location returns an undefined value.

Reset
REQ-025 While clear=0, the FSM SHALL go to IDLE immediately, with busy=0, done=0, error=0, read_data=0 and the wait counter at 0.
REQ-026 An in-flight write interrupted by reset before its commit edge SHALL NOT modify RAM.
REQ-027 RAM contents SHALL NOT be altered by reset.
REQ-028 After clear deasserts, the first edge with a valid request SHALL be treated as E0.

Configuration
REQ-029 The macro MEM_CTRL_WAIT_EN SHALL control the wait-state feature.
REQ-030 With MEM_CTRL_WAIT_EN defined, the WAIT state and counter SHALL be compiled in as specified above.
REQ-031 With MEM_CTRL_WAIT_EN undefined, the WAIT state and counter SHALL be absent and WAIT_CYCLES ignored, so the FSM goes IDLE->XFER->DONE with done in the cycle after edge E0+1.

Verification (WAIT_CYCLES=2, macro defined unless stated)
REQ-032 Write, then read: write 0xDEADBEEF to 0x010, then read 0x010 -> busy for 3 cycles after E0, done 1 cycle later, read_data=0xDEADBEEF.
REQ-033 Both requests high in IDLE -> error=1 for 1 cycle, busy stays 0, RAM and read_data unchanged.
REQ-034 clear pulsed low during WAIT of a write of 0x12345678 to 0x020 (which holds 0xAAAA5555) -> outputs 0 at once, later read of 0x020 returns 0xAAAA5555.
REQ-035 read_req held high continuously at 0x001 -> done pulses exactly every 5 cycles, read_data stable between pulses.
REQ-036 Macro undefined, write 0x0F0F0F0F to 0x1FF, then read it -> done in the cycle after E0+1, read_data=0x0F0F0F0F.
REQ-037 Address changed and write_req dropped during WAIT -> the latched address and data are used, done still pulses.
